regfile_32x32: RTL and testbench



---
 rtl/regfile_32x32.sv | 61 ++++++
 tb/tb_regfile_32x32.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/regfile_32x32.sv
// MIPS register file: 32 x 32-bit, two combinational read ports, one synchronous write port.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-through forwarding to both read ports.
module regfile_32x32 #(
  parameter int          WIDTH    = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] SP_RESET = 32'h0000_7FFC,
  parameter logic [31:0] GP_RESET = 32'h0000_1800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [WIDTH-1:0]  wd3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_en;

  // $0 is never written, so its storage stays at its reset value of zero.
  assign wr_en = we3 && (a3 != '0);

  // NOTE: every register is reset explicitly; this is a flop array, not a RAM
  // macro, and $sp/$gp need non-zero start values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == 28)      regs[i] <= GP_RESET[WIDTH-1:0];
        else if (i == 29) regs[i] <= SP_RESET[WIDTH-1:0];
        else              regs[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking so every read in this edge sees the pre-edge array.
      regs[a3] <= wd3;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = wr_en && !rst;
`endif

  // NOTE: outputs get a default first so no path through this block infers a latch.
  always_comb begin
    rd1 = regs[a1];
    rd2 = regs[a2];
`ifdef REGFILE_BYPASS_EN
    if (fwd_ok && (a3 == a1)) rd1 = wd3;
    if (fwd_ok && (a3 == a2)) rd2 = wd3;
`endif
    // Register 0 reads zero even before the first reset has cleared the array.
    if (a1 == '0) rd1 = '0;
    if (a2 == '0) rd2 = '0;
  end

endmodule

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32: behavioural model feeds a scoreboard queue of expected reads.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        we3;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];

  regfile_32x32 dut (
    .clk (clk),
    .rst (rst),
    .we3 (we3),
    .a1  (a1),
    .a2  (a2),
    .a3  (a3),
    .wd3 (wd3),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we3 && !rst && a3 != 5'd0 && a3 == addr) return wd3;
`endif
    return model[addr];
  endfunction

  // One rising edge; the model takes the same update the spec requires of the array.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[28] = 32'h0000_1800;
      model[29] = 32'h0000_7FFC;
    end else if (we3 && a3 != 5'd0) begin
      model[a3] = wd3;
    end
    #1;
  endtask

  task automatic expect_read(input string tag, input logic [4:0] x1, input logic [4:0] x2);
    exp_t e;
    a1 = x1;
    a2 = x2;
    sb.push_back('{tag: {tag, "/rd1"}, port: 1, exp: exp_rd(x1)});
    sb.push_back('{tag: {tag, "/rd2"}, port: 2, exp: exp_rd(x2)});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, (e.port == 1) ? rd1 : rd2, e.exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b0; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    #2;
    expect_read("pre_reset_r0", 5'd0, 5'd0);

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    expect_read("rst_r0", 5'd0, 5'd0);
    expect_read("rst_gp", 5'd28, 5'd5);
    expect_read("rst_sp", 5'd29, 5'd29);

    we3 = 1'b1; a3 = 5'd8; wd3 = 32'hDEAD_BEEF;
    cycle();
    we3 = 1'b0;
    expect_read("wr8", 5'd8, 5'd9);

    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFF_FFFF;
    cycle();
    we3 = 1'b0;
    expect_read("wr0", 5'd0, 5'd0);

    a3 = 5'd8; wd3 = 32'h1234_5678;
    cycle();
    expect_read("hold8", 5'd8, 5'd8);

    // Reset raised between edges: nothing changes until the edge, and the write is lost.
    rst = 1'b1; we3 = 1'b1; a3 = 5'd10; wd3 = 32'hA5A5_A5A5;
    expect_read("rst_pending", 5'd8, 5'd10);
    cycle();
    rst = 1'b0; we3 = 1'b0;
    expect_read("rst_prio", 5'd10, 5'd29);
    expect_read("rst_clr8", 5'd8, 5'd28);

    we3 = 1'b1; a3 = 5'd12; wd3 = 32'h0000_00FF;
    expect_read("rdw_pre", 5'd12, 5'd12);
    cycle();
    we3 = 1'b0;
    expect_read("rdw_post", 5'd12, 5'd12);

    we3 = 1'b1; a3 = 5'd13; wd3 = 32'h0BAD_F00D;
    expect_read("rdw_p2", 5'd5, 5'd13);
    cycle();
    we3 = 1'b0;

    we3 = 1'b1; a3 = 5'd31; wd3 = 32'h8000_0001;
    cycle();
    we3 = 1'b0;
    expect_read("wr31", 5'd31, 5'd13);

    for (int i = 0; i < 60; i++) begin
      we3 = 1'($urandom_range(1, 0));
      a3  = 5'($urandom_range(31, 0));
      wd3 = $urandom;
      expect_read("rand", 5'($urandom_range(31, 0)), a3);
      cycle();
    end
    we3 = 1'b0;

    for (int i = 0; i < 32; i += 2) begin
      expect_read("sweep", 5'(i), 5'(i + 1));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
